// File: rtl/sm_pkg.sv
// ---------------------------------------------------------------------------
// sm_pkg
// Shared definitions for the sign-magnitude accumulator slice.
//   WIDTH            : total word width (sign + magnitude)
//   MAG_W            : magnitude width
//   sm_word_t        : packed sign-magnitude word {sign, mag}
//   sm_accum_state_t : sequencer states IDLE / ACCUM / DONE
//   SM_MAG_MAX       : largest representable magnitude (all ones)
//   sm_normalize()   : forces a zero magnitude to carry a positive sign
// ---------------------------------------------------------------------------
package sm_pkg;

  localparam int WIDTH = 21;
  localparam int MAG_W = WIDTH - 1;

  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
  } sm_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } sm_accum_state_t;

  localparam logic [MAG_W-1:0] SM_MAG_MAX = '1;

  // There is exactly one encoding of zero: +0.
  function automatic sm_word_t sm_normalize(input sm_word_t w);
    sm_word_t r;
    r.mag  = w.mag;
    r.sign = w.sign & (|w.mag);
    return r;
  endfunction

endpackage

// File: rtl/sm_add_norm.sv
// ---------------------------------------------------------------------------
// sm_add_norm
// Combinational sign-magnitude adder with zero-sign normalization.
//   a    in  sm_word_t  accumulator operand
//   b    in  sm_word_t  incoming term
//   sum  out sm_word_t  a (+) b, never negative zero
//   ovf  out 1          carry out of the magnitude on a same-sign add
// Build option SM_ACCUM_SATURATE_EN: on overflow the magnitude clamps to
// SM_MAG_MAX with the common sign; otherwise the carry is dropped (wrap).
// ---------------------------------------------------------------------------
module sm_add_norm
  import sm_pkg::*;
(
  input  sm_word_t a,
  input  sm_word_t b,
  output sm_word_t sum,
  output logic     ovf
);

  logic [MAG_W:0]   mag_add;
  logic [MAG_W-1:0] diff_ab;
  logic [MAG_W-1:0] diff_ba;
  logic             a_ge_b;

  assign mag_add = {1'b0, a.mag} + {1'b0, b.mag};
  assign diff_ab = a.mag - b.mag;
  assign diff_ba = b.mag - a.mag;
  assign a_ge_b  = (a.mag >= b.mag);

  logic [MAG_W-1:0] mag_r;
  logic             sign_r;

  // NOTE: every signal written here gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    mag_r  = '0;
    sign_r = 1'b0;
    ovf    = 1'b0;
    if (a.sign == b.sign) begin
      sign_r = a.sign;
      ovf    = mag_add[MAG_W];
`ifdef SM_ACCUM_SATURATE_EN
      mag_r  = mag_add[MAG_W] ? SM_MAG_MAX : mag_add[MAG_W-1:0];
`else
      mag_r  = mag_add[MAG_W-1:0];
`endif
    end else if (a_ge_b) begin
      // Larger magnitude decides the sign; a tie yields zero, fixed below.
      sign_r = a.sign;
      mag_r  = diff_ab;
    end else begin
      sign_r = b.sign;
      mag_r  = diff_ba;
    end
  end

  // A wrapped same-sign add can also land on zero, so normalize every path.
  assign sum.mag  = mag_r;
  assign sum.sign = sign_r & (|mag_r);

endmodule

// File: rtl/sm_accum_ctrl.sv
// ---------------------------------------------------------------------------
// sm_accum_ctrl
// Accumulates `len` sign-magnitude terms onto a bias for one MLP neuron and
// presents the sum on a valid/ready output.
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   begin a job (sampled in IDLE only)
//   len        in   CNT_W  term count, clamped to MAX_TERMS
//   bias       in   WIDTH  initial accumulator value
//   in_valid   in   term available
//   in_ready   out  term accepted this cycle (ACCUM only)
//   in_data    in   WIDTH  sign-magnitude term
//   out_valid  out  result available (DONE only)
//   out_ready  in   consumer takes the result
//   out_data   out  WIDTH  accumulated result
//   out_ovf    out  sticky magnitude overflow for the current job
//   busy       out  state is not IDLE
// Build option SM_ACCUM_SATURATE_EN selects saturating instead of wrapping
// overflow behaviour inside sm_add_norm.
// ---------------------------------------------------------------------------
module sm_accum_ctrl
  import sm_pkg::*;
#(
  parameter int MAX_TERMS = 64,
  parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [WIDTH-1:0] bias,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

  sm_accum_state_t  state, state_d;
  sm_word_t         acc, acc_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             ovf, ovf_d;

  sm_word_t         add_sum;
  logic             add_ovf;
  logic [CNT_W-1:0] len_clamped;

  assign len_clamped = (len > MAX_CNT) ? MAX_CNT : len;

  sm_add_norm u_add (
    .a   (acc),
    .b   (sm_word_t'(in_data)),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // NOTE: state registers use non-blocking assignments so every flop
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      cnt   <= cnt_d;
      ovf   <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state;
    acc_d     = acc;
    cnt_d     = cnt;
    ovf_d     = ovf;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          acc_d   = sm_normalize(sm_word_t'(bias));
          cnt_d   = len_clamped;
          ovf_d   = 1'b0;
          state_d = (len_clamped == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = add_sum;
          cnt_d = cnt - CNT_W'(1);
          ovf_d = ovf | add_ovf;
          if (cnt == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The result is only exposed in DONE; elsewhere the bus stays quiet.
  assign out_data = (state == DONE) ? acc : '0;
  assign out_ovf  = ovf;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_sm_accum_ctrl.sv
module tb_sm_accum_ctrl;

  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] len;
  logic [20:0]      bias;
  logic             in_valid;
  logic             in_ready;
  logic [20:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [20:0]      out_data;
  logic             out_ovf;
  logic             busy;

  sm_accum_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [20:0] data;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[$];
  logic [20:0] tq[$];
  int          errors  = 0;
  int          checks  = 0;
  int          accepts = 0;
  int          pushes  = 0;
  int          pops    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_result(input logic [20:0] d, input logic o);
    exp_t e;
    e.data = d;
    e.ovf  = o;
    exp_q.push_back(e);
    pushes++;
  endtask

  // Monitor: counts accepted terms and scores every output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && in_valid && in_ready) accepts++;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got 0x%0h expected none", out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_data", {11'd0, out_data}, {11'd0, e.data});
        check("out_ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
        pops++;
      end
    end
  end

  task automatic start_job(input logic [20:0] b, input logic [CNT_W-1:0] n, input string tag);
    start = 1'b1;
    bias  = b;
    len   = n;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
  endtask

  // Sends tq; with gaps, in_valid drops for one cycle between terms.
  task automatic send_terms(input bit gaps, input string tag);
    int  base;
    bit  done;
    base = accepts;
    foreach (tq[i]) begin
      if (gaps && i > 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = tq[i];
      done     = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
        @(negedge clk);
        if (out_valid) check({tag, "_early_valid"}, {31'd0, out_valid}, 32'd0);
        if (in_ready) done = 1'b1;
        @(posedge clk); #1;
      end
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL %s_accept_timeout: got no accept expected accept", tag);
      end
    end
    in_valid = 1'b0;
    check({tag, "_accepts"}, accepts - base, tq.size());
  endtask

  // Called one #1 after the final accept (or start for len==0); out_ready=1.
  task automatic finish_job(input string tag);
    @(negedge clk);
    check({tag, "_valid_timing"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_idle"}, {30'd0, out_valid, busy}, 32'd0);
  endtask

  initial begin
    #100us;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; bias = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {in_ready, out_valid, out_data, out_ovf, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic sum: 5 + 3 - 10 + 1 = -1
    expect_result(21'h100001, 1'b0);
    start_job(21'h000005, 7'd3, "basic");
    tq = {21'h000003, 21'h10000A, 21'h000001};
    send_terms(1'b0, "basic");
    finish_job("basic");

    // Zero-length job
    expect_result(21'h100007, 1'b0);
    start_job(21'h100007, 7'd0, "zero_len");
    finish_job("zero_len");

    // -4 + 4 normalizes to +0
    expect_result(21'h000000, 1'b0);
    start_job(21'h100004, 7'd1, "negzero");
    tq = {21'h000004};
    send_terms(1'b0, "negzero");
    finish_job("negzero");

    // Bias -0 normalized on load
    expect_result(21'h000000, 1'b0);
    start_job(21'h100000, 7'd0, "bias_negzero");
    finish_job("bias_negzero");

    // Overflow: 0xFFFFF + 2
`ifdef SM_ACCUM_SATURATE_EN
    expect_result(21'h0FFFFF, 1'b1);
`else
    expect_result(21'h000001, 1'b1);
`endif
    start_job(21'h0FFFFF, 7'd1, "ovf");
    tq = {21'h000002};
    send_terms(1'b0, "ovf");
    finish_job("ovf");

    // Gapped input, stalled output, ignored start: 16-32+5-3+100 = 86
    out_ready = 1'b0;
    expect_result(21'h000056, 1'b0);
    start_job(21'h000010, 7'd4, "bp");
    tq = {21'h100020, 21'h000005, 21'h100003, 21'h000064};
    send_terms(1'b1, "bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_stall_valid", {31'd0, out_valid}, 32'd1);
      check("bp_stall_data", {11'd0, out_data}, 32'h56);
      check("bp_stall_ovf", {31'd0, out_ovf}, 32'd0);
      @(posedge clk); #1;
      if (i == 1) begin
        start = 1'b1; bias = 21'h000777; len = 7'd1;
      end
      if (i == 2) start = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    check("bp_idle_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("bp_start_ignored", {31'd0, busy}, 32'd0);

    // Reset mid-job after 2 of 4 terms
    start_job(21'h000100, 7'd4, "rst_job");
    tq = {21'h000001, 21'h000002};
    send_terms(1'b0, "rst_job");
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", {in_ready, out_valid, out_data, out_ovf, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    expect_result(21'h000006, 1'b0);
    start_job(21'h000003, 7'd2, "post_rst");
    tq = {21'h100001, 21'h000004};
    send_terms(1'b0, "post_rst");
    finish_job("post_rst");

    // len above MAX_TERMS clamps to 64 terms of +1
    expect_result(21'h000040, 1'b0);
    start_job(21'h000000, 7'd100, "clamp");
    tq.delete();
    for (int i = 0; i < 64; i++) tq.push_back(21'h000001);
    send_terms(1'b0, "clamp");
    finish_job("clamp");

    repeat (2) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("results_seen", pops, pushes);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sm_accum_ctrl.md
# sm_accum_ctrl

Sequencer that accumulates a stream of 21-bit sign-magnitude terms (bit 20 = sign, bits 19:0 = magnitude) onto a bias for one MLP neuron. It loads the bias, consumes exactly `len` terms over a valid/ready input stream through one combinational sign-magnitude adder, and presents the final sum on a valid/ready output. It sits between the multiplier output stream and the activation stage.

## Interface
- `WIDTH`, 21: total word width, sign plus magnitude; magnitude is `WIDTH-1` bits.
- `MAX_TERMS`, 64: largest supported term count per job.
- `CNT_W`, `$clog2(MAX_TERMS+1)`: width of `len` and the internal counter.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a job; sampled only in IDLE.
- `len`  in  CNT_W  number of terms in the job, sampled with `start`; values above MAX_TERMS are clamped to MAX_TERMS.
- `bias`  in  WIDTH  initial accumulator value, sampled with `start`.
- `in_valid`  in  1  term available.
- `in_ready`  out  1  block accepts a term this cycle.
- `in_data`  in  WIDTH  sign-magnitude term.
- `out_valid`  out  1  result held stable.
- `out_ready`  in  1  consumer takes the result.
- `out_data`  out  WIDTH  accumulated sign-magnitude result.
- `out_ovf`  out  1  sticky magnitude-overflow flag for the current job.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE: `in_ready`=0, `out_valid`=0. When `start`=1: `acc`<=bias, `cnt`<=len, `ovf`<=0. Next state is DONE if len==0, otherwise ACCUM.
- ACCUM: `in_ready`=1. On `in_valid && in_ready`: `acc`<=acc ⊕ in_data and `cnt`<=cnt-1. If cnt==1 at acceptance, next state is DONE.
- DONE: `out_valid`=1 and `out_data`=acc. On `out_ready`, return to IDLE.
- `start` outside IDLE is ignored. `in_valid` outside ACCUM is not accepted.
- Sign-magnitude add ⊕, with a = acc, b = term:
  - Equal signs: magnitude = |a| + |b|; sign = the common sign.
  - Different signs: magnitude = larger minus smaller; sign = sign of the larger-magnitude operand.
  - Any zero-magnitude result gets sign 0 (no negative zero). A bias of −0 is normalized to +0 on load.
- Overflow: with equal signs and a carry out of the magnitude, `ovf`<=1. The flag stays set until the next `start`. The magnitude then wraps: the carry is dropped.

## Timing
- Reset values: state IDLE, `acc`=0, `cnt`=0, `ovf`=0. All outputs are 0, including `in_ready`, `out_valid`, `out_data`, `out_ovf` and `busy`.
- Reset during any state aborts the job immediately. No partial result is emitted.
- One term is accepted per cycle with no bubbles, so a job with n terms and an always-valid source spends n cycles in ACCUM.
- `out_valid` rises the cycle after the last term is accepted, or the cycle after `start` when len==0.
- `out_data` and `out_ovf` stay stable while `out_valid`=1 and `out_ready`=0.
- Earliest next `start` is the cycle after the DONE handshake, since IDLE lasts at least one cycle.
- `busy` is registered from state; it goes high the cycle after `start` is accepted.

## Configuration
- Macro: `SM_ACCUM_SATURATE_EN`.
- Defined: on overflow the magnitude saturates to all-ones (0xFFFFF for WIDTH=21) and keeps the common sign. Later adds operate on the saturated value. `ovf` is still set.
- Undefined: the magnitude wraps as described under Operation. `ovf` is still set.

## Structure
- Shared package `sm_pkg`:
  - `WIDTH` and the `sm_word_t` typedef (sign bit plus magnitude).
  - State enum `sm_accum_state_t` with IDLE, ACCUM, DONE.
  - Constant `SM_MAG_MAX`.
- Sub-module `sm_add_norm`: a combinational sign-magnitude adder with zero-sign normalization. It outputs the sum and an overflow bit, and handles the saturate option internally. `sm_accum_ctrl` holds the FSM, counter and registers.

## Test plan
- Basic sum: bias=+5 (0x000005), len=3, terms +3, −10 (0x10000A), +1 → out_data=0x100001 (−1), out_ovf=0, `out_valid` the cycle after the third accept.
- Zero-length job: len=0, bias=−7 (0x100007) → `out_valid` the cycle after `start`, out_data=0x100007. No `in_ready` pulse occurs.
- Negative-zero normalization: bias=−4, term +4 → out_data=0x000000. Separately, bias=−0 (0x100000) with len=0 → out_data=0x000000.
- Overflow: bias=+0xFFFFF, term +2 → out_ovf=1. out_data=0x000001 without the macro; out_data=0x0FFFFF with `SM_ACCUM_SATURATE_EN`.
- Backpressure and gaps: in_valid toggles every other cycle and out_ready is held low for 5 cycles → every term is accepted exactly once, the result stays stable, and a `start` issued during DONE is ignored.
- Reset mid-job: assert `rst` after 2 of 4 terms → all outputs are 0 immediately. A new job started after reset gives the correct result with no residue from the aborted job.
